// File: rtl/icache_refill_unit_if.sv
// Bus bundle for icache_refill_unit: iCache request/response handshake plus L2 instruction channel.
// slave is the refill unit's view; master is the iCache/L2 environment's view.
interface icache_refill_unit_if #(
    parameter int unsigned LINE_SIZE = 128,
    parameter int unsigned BEATS     = 4,
    parameter int unsigned ADDR_SIZE = 32
);
    logic                         req_valid_i;
    logic                         req_ready_o;
    logic [ADDR_SIZE-1:0]         req_addr_i;
    logic                         kill_i;
    logic                         resp_valid_o;
    logic                         resp_ready_i;
    logic [LINE_SIZE*BEATS-1:0]   resp_line_o;
    logic [ADDR_SIZE-1:0]         resp_addr_o;
    logic                         err_o;
    logic [ADDR_SIZE-7:0]         l2_addr_o;
    logic                         l2_valid_o;
    logic [LINE_SIZE-1:0]         l2_line_i;
    logic                         l2_valid_i;
    logic [1:0]                   l2_seq_num_i;

    modport slave (
        input  req_valid_i, req_addr_i, kill_i, resp_ready_i,
        input  l2_line_i, l2_valid_i, l2_seq_num_i,
        output req_ready_o, resp_valid_o, resp_line_o, resp_addr_o, err_o,
        output l2_addr_o, l2_valid_o
    );

    modport master (
        output req_valid_i, req_addr_i, kill_i, resp_ready_i,
        output l2_line_i, l2_valid_i, l2_seq_num_i,
        input  req_ready_o, resp_valid_o, resp_line_o, resp_addr_o, err_o,
        input  l2_addr_o, l2_valid_o
    );
endinterface

// File: rtl/icache_refill_unit.sv
// iCache line refill: one L2 line request, collects 4 sequence-numbered beats, returns the line.
// Optional watchdog enabled by defining ICACHE_REFILL_TIMEOUT_EN (err_o tied low otherwise).
module icache_refill_unit #(
    parameter int unsigned LINE_SIZE      = 128,
    parameter int unsigned BEATS          = 4,
    parameter int unsigned ADDR_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    icache_refill_unit_if.slave  bus
);
    localparam int unsigned LineW = LINE_SIZE * BEATS;
    localparam int unsigned LaW   = ADDR_SIZE - 6;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LaW-1:0]   la_q, la_d;
    logic [LineW-1:0] line_q, line_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       cnt_inc;
    logic             beat_last;
    logic             err;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            tmo_hit;
`endif

    assign cnt_inc   = cnt_q + 3'd1;
    assign beat_last = (cnt_inc == 3'(BEATS));

    always_comb begin
        state_d = state_q;
        la_d    = la_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        err     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A request coinciding with a flush is dropped; stray beats are ignored here.
                if (bus.req_valid_i && !bus.kill_i) begin
                    la_d    = bus.req_addr_i[ADDR_SIZE-1:6];
                    cnt_d   = 3'd0;
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = bus.kill_i ? StDrain : StWait;
            end
            StWait: begin
                if (bus.l2_valid_i) begin
                    cnt_d = cnt_inc;
                    if (!bus.kill_i) begin
                        for (int i = 0; i < int'(BEATS); i++) begin
                            if (bus.l2_seq_num_i == 2'(i)) begin
                                line_d[i*LINE_SIZE +: LINE_SIZE] = bus.l2_line_i;
                            end
                        end
                    end
                end
                if (bus.kill_i) begin
                    // A beat accepted together with the kill still counts toward the drain.
                    state_d = (bus.l2_valid_i && beat_last) ? StIdle : StDrain;
                end else if (bus.l2_valid_i && beat_last) begin
                    state_d = StResp;
                end
            end
            StDrain: begin
                if (bus.l2_valid_i) begin
                    cnt_d = cnt_inc;
                    if (beat_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StResp: begin
                if (bus.kill_i || bus.resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef ICACHE_REFILL_TIMEOUT_EN
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if ((state_q == StWait || state_q == StDrain) && !bus.l2_valid_i) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
        if (tmo_hit) begin
            err     = 1'b1;
            state_d = StIdle;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            la_q    <= '0;
            line_q  <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            la_q    <= la_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ICACHE_REFILL_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign bus.req_ready_o  = (state_q == StIdle);
    assign bus.resp_valid_o = (state_q == StResp);
    assign bus.resp_line_o  = line_q;
    assign bus.resp_addr_o  = {la_q, 6'b0};
    assign bus.l2_addr_o    = la_q;
    assign bus.l2_valid_o   = (state_q == StReq);
`ifdef ICACHE_REFILL_TIMEOUT_EN
    assign bus.err_o        = err;
`else
    assign bus.err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill_unit.sv
// Scoreboard bench for icache_refill_unit: directed refills, expected lines queued, monitor compares.
module tb_icache_refill_unit;
    localparam int unsigned LineSize = 128;
    localparam int unsigned Beats    = 4;
    localparam int unsigned AddrSize = 32;
    localparam int unsigned LineW    = LineSize * Beats;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int unsigned TmoCycles = 8;
`else
    localparam int unsigned TmoCycles = 64;
`endif

    typedef struct packed {
        logic [LineW-1:0]    line;
        logic [AddrSize-1:0] addr;
    } resp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    icache_refill_unit_if #(.LINE_SIZE(LineSize), .BEATS(Beats), .ADDR_SIZE(AddrSize)) bus ();

    icache_refill_unit #(
        .LINE_SIZE      (LineSize),
        .BEATS          (Beats),
        .ADDR_SIZE      (AddrSize),
        .TIMEOUT_CYCLES (TmoCycles)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    resp_t            exp_q[$];
    resp_t            exp_e;
    int               n_pass  = 0;
    int               n_total = 0;
    logic [LineW-1:0] mdl;
    logic             strobe_prev = 1'b0;

    task automatic checkw(input string name, input logic [LineW-1:0] act,
                          input logic [LineW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        tick();
        bus.req_valid_i = 1'b0;
        check1("l2_valid_strobe", bus.l2_valid_o, 1'b1);
        checkw("l2_addr", LineW'(bus.l2_addr_o), LineW'(addr[31:6]));
        check1("req_ready_busy", bus.req_ready_o, 1'b0);
        tick();
        check1("l2_valid_one_cycle", bus.l2_valid_o, 1'b0);
        checkw("l2_addr_held", LineW'(bus.l2_addr_o), LineW'(addr[31:6]));
    endtask

    task automatic beat(input logic [1:0] seq, input logic [127:0] data, input bit store,
                        input int gap);
        bus.l2_valid_i   = 1'b1;
        bus.l2_seq_num_i = seq;
        bus.l2_line_i    = data;
        if (store) mdl[int'(seq)*LineSize +: LineSize] = data;
        tick();
        bus.l2_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic handshake();
        bus.resp_ready_i = 1'b1;
        tick();
        bus.resp_ready_i = 1'b0;
        check1("req_ready_after_hs", bus.req_ready_o, 1'b1);
        check1("resp_valid_after_hs", bus.resp_valid_o, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every response handshake; also guards the L2 strobe.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.l2_valid_o) check1("l2_valid_back_to_back", strobe_prev, 1'b0);
            strobe_prev = bus.l2_valid_o;
            if (bus.resp_valid_o && bus.resp_ready_i) begin
                if (exp_q.size() == 0) begin
                    check1("resp_unexpected", bus.resp_valid_o, 1'b0);
                end else begin
                    exp_e = exp_q.pop_front();
                    checkw("resp_line", bus.resp_line_o, exp_e.line);
                    checkw("resp_addr", LineW'(bus.resp_addr_o), LineW'(exp_e.addr));
                end
            end
        end else begin
            strobe_prev = 1'b0;
        end
    end

    initial begin
        int  first;
        int  pulses;
        bit  saw_valid;

        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.kill_i       = 1'b0;
        bus.resp_ready_i = 1'b0;
        bus.l2_line_i    = '0;
        bus.l2_valid_i   = 1'b0;
        bus.l2_seq_num_i = 2'd0;
        mdl              = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check1("rst_req_ready", bus.req_ready_o, 1'b1);
        check1("rst_resp_valid", bus.resp_valid_o, 1'b0);
        checkw("rst_resp_line", bus.resp_line_o, '0);
        checkw("rst_resp_addr", LineW'(bus.resp_addr_o), '0);
        check1("rst_l2_valid", bus.l2_valid_o, 1'b0);
        checkw("rst_l2_addr", LineW'(bus.l2_addr_o), '0);
        check1("rst_err", bus.err_o, 1'b0);
        rstn = 1'b1;
        tick();

        // In-order refill at 0x8000_1040
        request(32'h8000_1040);
        checkw("l2_addr_const", LineW'(bus.l2_addr_o), LineW'(26'h2000041));
        beat(2'd0, 128'hA, 1'b1, 0);
        beat(2'd1, 128'hB, 1'b1, 0);
        beat(2'd2, 128'hC, 1'b1, 0);
        check1("no_resp_before_last", bus.resp_valid_o, 1'b0);
        beat(2'd3, 128'hD, 1'b1, 0);
        check1("resp_valid_next_cycle", bus.resp_valid_o, 1'b1);
        checkw("line_slot0", LineW'(bus.resp_line_o[127:0]), LineW'(128'hA));
        checkw("line_slot3", LineW'(bus.resp_line_o[511:384]), LineW'(128'hD));
        checkw("resp_addr_t1", LineW'(bus.resp_addr_o), LineW'(32'h8000_1040));
        exp_q.push_back('{line: {128'hD, 128'hC, 128'hB, 128'hA}, addr: 32'h8000_1040});
        handshake();

        // Out-of-order beats with gaps; response back-pressured 5 cycles
        request(32'h1234_5678);
        beat(2'd3, 128'h3333_0003, 1'b1, 2);
        beat(2'd1, 128'h1111_0001, 1'b1, 2);
        beat(2'd0, 128'h0000_0000_0000_0000_0000_0000_F00D_0000, 1'b1, 2);
        beat(2'd2, 128'h2222_0002, 1'b1, 0);
        exp_q.push_back('{line: mdl, addr: 32'h1234_5640});
        for (int i = 0; i < 5; i++) begin
            check1("hold_valid", bus.resp_valid_o, 1'b1);
            checkw("hold_line", bus.resp_line_o, mdl);
            checkw("hold_addr", LineW'(bus.resp_addr_o), LineW'(32'h1234_5640));
            check1("hold_req_ready", bus.req_ready_o, 1'b0);
            tick();
        end
        handshake();

        // Kill after two beats; remaining beats drained without storing
        request(32'h0000_2000);
        beat(2'd0, 128'hDEAD_0000, 1'b1, 0);
        beat(2'd1, 128'hDEAD_0001, 1'b1, 0);
        bus.kill_i = 1'b1;
        tick();
        bus.kill_i = 1'b0;
        beat(2'd2, 128'hDEAD_0002, 1'b0, 1);
        check1("drain_not_ready", bus.req_ready_o, 1'b0);
        beat(2'd3, 128'hDEAD_0003, 1'b0, 0);
        check1("drain_done_ready", bus.req_ready_o, 1'b1);
        check1("drain_no_resp", bus.resp_valid_o, 1'b0);
        request(32'h0000_3000);
        beat(2'd2, 128'hBEEF_0002, 1'b1, 0);
        beat(2'd0, 128'hBEEF_0000, 1'b1, 1);
        beat(2'd3, 128'hBEEF_0003, 1'b1, 0);
        beat(2'd1, 128'hBEEF_0001, 1'b1, 0);
        exp_q.push_back('{line: {128'hBEEF_0003, 128'hBEEF_0002, 128'hBEEF_0001, 128'hBEEF_0000},
                          addr: 32'h0000_3000});
        handshake();

        // Kill during RESP with resp_ready low
        request(32'h4000_0080);
        beat(2'd0, 128'h4000, 1'b1, 0);
        beat(2'd1, 128'h4001, 1'b1, 0);
        beat(2'd2, 128'h4002, 1'b1, 0);
        beat(2'd3, 128'h4003, 1'b1, 0);
        check1("resp_before_kill", bus.resp_valid_o, 1'b1);
        bus.kill_i = 1'b1;
        tick();
        bus.kill_i = 1'b0;
        check1("resp_killed", bus.resp_valid_o, 1'b0);
        check1("resp_kill_idle", bus.req_ready_o, 1'b1);

        // Request and kill in the same cycle
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h5555_5540;
        bus.kill_i      = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        bus.kill_i      = 1'b0;
        check1("reqkill_no_strobe", bus.l2_valid_o, 1'b0);
        check1("reqkill_ready", bus.req_ready_o, 1'b1);
        tick();
        check1("reqkill_no_strobe2", bus.l2_valid_o, 1'b0);

        // Stray beat in IDLE ignored; duplicate seq overwrites and counts, slot 3 stays stale
        beat(2'd1, 128'hBAD, 1'b0, 0);
        check1("stray_beat_idle", bus.req_ready_o, 1'b1);
        request(32'h0000_5000);
        beat(2'd0, 128'h5000, 1'b1, 0);
        beat(2'd0, 128'h5A00, 1'b1, 0);
        beat(2'd1, 128'h5001, 1'b1, 0);
        check1("dup_not_done", bus.resp_valid_o, 1'b0);
        beat(2'd2, 128'h5002, 1'b1, 0);
        check1("dup_counts", bus.resp_valid_o, 1'b1);
        exp_q.push_back('{line: {128'h4003, 128'h5002, 128'h5001, 128'h5A00},
                          addr: 32'h0000_5000});
        handshake();

        // Asynchronous reset mid-refill; late beats ignored in IDLE
        request(32'h7777_7000);
        beat(2'd0, 128'h7000, 1'b1, 0);
        #2 rstn = 1'b0;
        #1;
        check1("arst_ready", bus.req_ready_o, 1'b1);
        check1("arst_resp_valid", bus.resp_valid_o, 1'b0);
        checkw("arst_l2_addr", LineW'(bus.l2_addr_o), '0);
        checkw("arst_line", bus.resp_line_o, '0);
        mdl = '0;
        tick();
        rstn = 1'b1;
        beat(2'd1, 128'h7001, 1'b0, 0);
        beat(2'd2, 128'h7002, 1'b0, 0);
        beat(2'd3, 128'h7003, 1'b0, 0);
        check1("late_beats_ready", bus.req_ready_o, 1'b1);
        check1("late_beats_no_resp", bus.resp_valid_o, 1'b0);

        // Only two beats returned: watchdog fires when enabled, otherwise the refill waits
        request(32'h0000_9000);
        beat(2'd0, 128'h9000, 1'b1, 0);
        beat(2'd1, 128'h9001, 1'b1, 0);
        first     = -1;
        pulses    = 0;
        saw_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.err_o) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (bus.resp_valid_o) saw_valid = 1'b1;
            tick();
        end
        check1("tmo_no_resp", saw_valid, 1'b0);
`ifdef ICACHE_REFILL_TIMEOUT_EN
        checkw("tmo_pulse_count", LineW'(pulses), LineW'(1));
        checkw("tmo_pulse_cycle", LineW'(first), LineW'(8));
        check1("tmo_ready_after", bus.req_ready_o, 1'b1);
`else
        checkw("no_err_pulses", LineW'(pulses), '0);
        check1("still_waiting", bus.req_ready_o, 1'b0);
        beat(2'd2, 128'h9002, 1'b1, 0);
        beat(2'd3, 128'h9003, 1'b1, 0);
        exp_q.push_back('{line: mdl, addr: 32'h0000_9000});
        handshake();
`endif

        tick();
        checkw("scoreboard_drained", LineW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
